// File: rtl/bp_update_sequencer_if.sv
// bp_update_sequencer_if: prediction, resolve, training and init bundle for the update sequencer
interface bp_update_sequencer_if #(
  parameter int PC_W          = 10,
  parameter int DEPTH         = 8,
  parameter int TABLE_ENTRIES = 1024
);
  localparam int IDX_W = $clog2(TABLE_ENTRIES);
  localparam int OCC_W = $clog2(DEPTH + 1);
  logic             pred_valid;
  logic             pred_ready;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_local;
  logic             pred_global;
  logic             pred_final;
  logic             res_valid;
  logic             res_taken;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic             upd_choice_we;
  logic             upd_choice_local;
  logic             mispredict;
  logic             init_we;
  logic [IDX_W-1:0] init_idx;
  logic             init_done;
  logic [OCC_W-1:0] occupancy;
  logic             res_error;
  modport slave (
    input  pred_valid, pred_pc, pred_local, pred_global, pred_final, res_valid, res_taken,
    output pred_ready, upd_valid, upd_pc, upd_taken, upd_choice_we, upd_choice_local,
           mispredict, init_we, init_idx, init_done, occupancy, res_error
  );
  modport master (
    output pred_valid, pred_pc, pred_local, pred_global, pred_final, res_valid, res_taken,
    input  pred_ready, upd_valid, upd_pc, upd_taken, upd_choice_we, upd_choice_local,
           mispredict, init_we, init_idx, init_done, occupancy, res_error
  );
endinterface

// File: rtl/bp_update_sequencer.sv
// bp_update_sequencer: clears predictor tables, queues in-flight predictions, issues training writes
module bp_update_sequencer #(
  parameter int PC_W          = 10,
  parameter int DEPTH         = 8,
  parameter int TABLE_ENTRIES = 1024
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  bp_update_sequencer_if.slave   bus
);
  localparam int IDX_W = $clog2(TABLE_ENTRIES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t           r_state, w_state_nxt;
  logic             r_init_we, w_init_we_nxt;
  logic [IDX_W-1:0] r_init_idx, w_init_idx_nxt;
  logic             r_init_done, w_init_done_nxt;
  logic             w_last;
  logic [PC_W-1:0]  r_pc [DEPTH];
  logic [DEPTH-1:0] r_loc, r_glb, r_fin;
  logic [PTR_W-1:0] r_head, r_tail;
  logic [OCC_W-1:0] r_occ;
  logic             w_ready, w_push, w_pop, w_mis;
  logic             r_upd_valid, r_upd_taken, r_choice_we, r_choice_local, r_mis, r_err;
  logic [PC_W-1:0]  r_upd_pc;
  assign w_last  = r_init_idx == IDX_W'(TABLE_ENTRIES - 1);
  assign w_ready = (r_state == S_RUN) && (r_occ != OCC_W'(DEPTH));
  assign w_push  = bus.pred_valid && w_ready;
  assign w_pop   = bus.res_valid && (r_occ != '0);
  assign w_mis   = w_pop && (r_fin[r_head] != bus.res_taken);
  // sweep sequencing: first cycle after reset raises the strobe at idx 0, last index hands over to RUN
  always_comb begin
    w_state_nxt     = r_state;
    w_init_we_nxt   = 1'b0;
    w_init_idx_nxt  = r_init_idx;
    w_init_done_nxt = r_init_done;
    if (r_state == S_INIT) begin
      w_init_we_nxt  = !(r_init_we && w_last);
      w_init_idx_nxt = (r_init_we && !w_last) ? r_init_idx + IDX_W'(1) : r_init_idx;
      if (r_init_we && w_last) begin
        w_state_nxt     = S_RUN;
        w_init_done_nxt = 1'b1;
      end
    end
  end
  // state and sweep registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_INIT;
      r_init_we   <= 1'b0;
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_we   <= w_init_we_nxt;
      r_init_idx  <= w_init_idx_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end
  // queue payload; contents are only meaningful between head and tail so no reset is needed
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_pc[r_tail]  <= bus.pred_pc;
      r_loc[r_tail] <= bus.pred_local;
      r_glb[r_tail] <= bus.pred_global;
      r_fin[r_tail] <= bus.pred_final;
    end
  end
  // queue pointers and occupancy; a mispredict discards everything younger, including this cycle's push
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (w_mis) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_head <= w_pop ? r_head + PTR_W'(1) : r_head;
      r_tail <= w_push ? r_tail + PTR_W'(1) : r_tail;
      r_occ  <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end
  // training write, mispredict pulse and sticky illegal-resolve flag, all one cycle after resolve
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_upd_valid    <= 1'b0;
      r_upd_pc       <= '0;
      r_upd_taken    <= 1'b0;
      r_choice_we    <= 1'b0;
      r_choice_local <= 1'b0;
      r_mis          <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_upd_valid    <= w_pop;
      r_upd_pc       <= w_pop ? r_pc[r_head] : '0;
      r_upd_taken    <= w_pop && bus.res_taken;
      r_choice_we    <= w_pop && (r_loc[r_head] ^ r_glb[r_head]);
      r_choice_local <= w_pop && (r_loc[r_head] == bus.res_taken);
      r_mis          <= w_mis;
      r_err          <= r_err || (bus.res_valid && (r_occ == '0));
    end
  end
  assign bus.pred_ready       = w_ready;
  assign bus.occupancy        = r_occ;
  assign bus.upd_valid        = r_upd_valid;
  assign bus.upd_pc           = r_upd_pc;
  assign bus.upd_taken        = r_upd_taken;
  assign bus.upd_choice_we    = r_choice_we;
  assign bus.upd_choice_local = r_choice_local;
  assign bus.mispredict       = r_mis;
  assign bus.init_we          = r_init_we;
  assign bus.init_idx         = r_init_idx;
  assign bus.init_done        = r_init_done;
  assign bus.res_error        = r_err;
endmodule

// File: tb/tb_bp_update_sequencer.sv
// tb_bp_update_sequencer: directed plus random stimulus checked against a queue-based reference model
module tb_bp_update_sequencer;
  localparam int PC_W  = 10;
  localparam int DEPTH = 8;
  localparam int TE    = 1024;
  typedef struct {
    logic [PC_W-1:0] pc;
    logic l, g, f;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  bp_update_sequencer_if #(.PC_W(PC_W), .DEPTH(DEPTH), .TABLE_ENTRIES(TE)) bus ();
  bp_update_sequencer #(.PC_W(PC_W), .DEPTH(DEPTH), .TABLE_ENTRIES(TE)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );
  ent_t q[$];
  int k;
  logic m_err;
  logic e_uv, e_ut, e_cw, e_cl, e_mis;
  logic [PC_W-1:0] e_pc;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask
  task automatic check_all();
    logic run, we;
    run = k > TE;
    we  = (k >= 1) && (k <= TE);
    chk("upd_valid", bus.upd_valid, e_uv);
    chk("upd_pc", bus.upd_pc, e_pc);
    chk("upd_taken", bus.upd_taken, e_ut);
    chk("upd_choice_we", bus.upd_choice_we, e_cw);
    chk("upd_choice_local", bus.upd_choice_local, e_cl);
    chk("mispredict", bus.mispredict, e_mis);
    chk("occupancy", bus.occupancy, q.size());
    chk("pred_ready", bus.pred_ready, run && (q.size() < DEPTH));
    chk("res_error", bus.res_error, m_err);
    chk("init_we", bus.init_we, we);
    chk("init_done", bus.init_done, run);
    if (we || k == 0) chk("init_idx", bus.init_idx, (k == 0) ? 0 : k - 1);
  endtask
  task automatic step(logic pv, logic [PC_W-1:0] pc, logic l, logic g, logic f, logic rv, logic rt);
    logic push;
    bus.pred_valid = pv; bus.pred_pc = pc; bus.pred_local = l;
    bus.pred_global = g; bus.pred_final = f; bus.res_valid = rv; bus.res_taken = rt;
    push = pv && (k > TE) && (q.size() < DEPTH);
    {e_uv, e_ut, e_cw, e_cl, e_mis} = '0;
    e_pc = '0;
    if (rv && q.size() == 0) m_err = 1'b1;
    if (rv && q.size() > 0) begin
      ent_t h;
      h = q.pop_front();
      e_uv = 1'b1; e_pc = h.pc; e_ut = rt;
      e_cw = h.l ^ h.g; e_cl = (h.l == rt); e_mis = (h.f != rt);
      if (e_mis) begin
        q.delete();
        push = 1'b0;
      end
    end
    if (push) q.push_back('{pc, l, g, f});
    @(posedge clk);
    #1;
    k++;
    check_all();
  endtask
  task automatic idle(int n);
    repeat (n) step(0, '0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset(int hold);
    bus.pred_valid = 0; bus.pred_pc = '0; bus.pred_local = 0; bus.pred_global = 0;
    bus.pred_final = 0; bus.res_valid = 0; bus.res_taken = 0;
    rst_n = 1'b0;
    q.delete();
    k = 0;
    m_err = 1'b0;
    {e_uv, e_ut, e_cw, e_cl, e_mis} = '0;
    e_pc = '0;
    #1;
    check_all();
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    #2;
    do_reset(2);
    idle(100);
    step(1, 10'h155, 1, 0, 1, 1, 1);
    idle(400);
    do_reset(2);
    idle(TE + 1);
    step(1, 10'h010, 0, 0, 1, 0, 0);
    step(1, 10'h020, 1, 1, 1, 0, 0);
    step(1, 10'h030, 0, 1, 1, 0, 0);
    repeat (3) step(0, '0, 0, 0, 0, 1, 1);
    idle(1);
    step(1, 10'h3ff, 1, 1, 1, 1, 1);
    step(0, '0, 0, 0, 0, 1, 1);
    for (int i = 0; i < DEPTH; i++)
      step(1, PC_W'(i * 4 + 1), 1'($urandom), 1'($urandom), 1, 0, 0);
    step(1, 10'h2aa, 1, 0, 1, 0, 0);
    step(1, 10'h155, 0, 0, 1, 1, 1);
    step(1, 10'h156, 1, 1, 1, 1, 1);
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step(0, '0, 0, 0, 0, 1, 1);
    step(1, 10'h100, 1, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, PC_W'(10'h200 + i), 0, 1, 0, 0, 0);
    step(1, 10'h2ff, 0, 0, 0, 1, 1);
    idle(1);
    repeat (400) begin
      logic rt;
      rt = 1'($urandom);
      if (q.size() > 0 && ($urandom % 4 != 0)) rt = q[0].f;
      step(($urandom % 4) != 0, PC_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom % 3) == 0, rt);
    end
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step(0, '0, 0, 0, 0, 1, !q[0].f);
    for (int i = 0; i < 5; i++) step(1, PC_W'(10'h040 + i), 1'($urandom), 1'($urandom), 1, 0, 0);
    chk("occupancy_before_reset", bus.occupancy, 5);
    do_reset(1);
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
